top_level: RTL and testbench

TOP_LEVEL -- requirements
Module: top_level

---
 rtl/top_level_pkg.sv | 39 +++
 rtl/top_level_pbit_node.sv | 28 ++
 rtl/top_level.sv | 74 +++++++
 tb/tb_top_level.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/top_level_pkg.sv
// Shared types and constants for the 3-node p-bit Ising network.
// Holds Q1.15 / 8-bit input types, tanh ROM, default weights and LFSR taps.
package top_level_pkg;

    typedef logic signed [15:0] q15_t;
    typedef logic signed [7:0]  i8_t;

    // Feedback taps q[31], q[21], q[1], q[0]
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    localparam i8_t B1_DEF  = 8'sd1;
    localparam i8_t B2_DEF  = -8'sd1;
    localparam i8_t B3_DEF  = -8'sd2;
    localparam i8_t J12_DEF = -8'sd1;
    localparam i8_t J13_DEF = 8'sd2;
    localparam i8_t J23_DEF = 8'sd2;

    // round(tanh(I) * 32767) for I = -8 .. +7, index = I + 8
    localparam q15_t TANH_ROM [16] = '{
        -16'sd32767, -16'sd32767, -16'sd32767, -16'sd32764,
        -16'sd32745, -16'sd32605, -16'sd31588, -16'sd24955,
        16'sd0,      16'sd24955,  16'sd31588,  16'sd32605,
        16'sd32745,  16'sd32764,  16'sd32767,  16'sd32767
    };

    // Clamp to [-8, +7] and offset by 8 to form the ROM index
    function automatic logic [3:0] rom_idx(i8_t i);
        if (i > 8'sd7)
            return 4'd15;
        if (i < -8'sd8)
            return 4'd0;
        return {~i[3], i[2:0]};
    endfunction

    function automatic logic [31:0] lfsr_next(logic [31:0] q);
        return {q[30:0], ^(q & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/top_level_pbit_node.sv
// One p-bit evaluator: clamp + tanh ROM + signed comparator.
// Ports: CLK, RST, load (capture I), i_in (field), r (sample), t (tanh), bit_out.
module pbit_node
    import top_level_pkg::*;
(
    input  logic               CLK,
    input  logic               RST,
    input  logic               load,
    input  logic signed [7:0]  i_in,
    input  logic signed [15:0] r,
    output logic signed [15:0] t,
    output logic               bit_out
);

    // Registered clamped input, kept in offset (ROM index) form
    logic [3:0] idx;

    always_ff @(posedge CLK) begin
        if (RST)
            idx <= 4'd8;
        else if (load)
            idx <= rom_idx(i_in);
    end

    assign t       = TANH_ROM[idx];
    assign bit_out = (t > r);

endmodule

// File: rtl/top_level.sv
// 3-node p-bit Ising network, Gibbs-sampled one node per two cycles.
// Ports: CLK, RST (sync, active-high), out1..out3 (1 = spin +1, 0 = spin -1).
module top_level
    import top_level_pkg::*;
#(
    parameter logic [31:0]        LFSR_SEED = 32'hACE1_2345,
    parameter logic signed [7:0]  B1  = B1_DEF,
    parameter logic signed [7:0]  B2  = B2_DEF,
    parameter logic signed [7:0]  B3  = B3_DEF,
    parameter logic signed [7:0]  J12 = J12_DEF,
    parameter logic signed [7:0]  J13 = J13_DEF,
    parameter logic signed [7:0]  J23 = J23_DEF
) (
    input  logic CLK,
    input  logic RST,
    output logic out1,
    output logic out2,
    output logic out3
);

    logic [31:0] lfsr;
    logic [2:0]  phase;
    i8_t         field;
    q15_t        r_smp;
    logic        node_bit;

    // Coupling contribution J * m for a bipolar spin stored as a bit
    function automatic i8_t jm(i8_t j, logic s);
        return s ? j : i8_t'(-j);
    endfunction

    // Local field for the node selected by phase[2:1]
    always_comb begin
        field = '0;
        case (phase[2:1])
            2'd0: field = B1 + jm(J12, out2) + jm(J13, out3);
            2'd1: field = B2 + jm(J12, out1) + jm(J23, out3);
            2'd2: field = B3 + jm(J13, out1) + jm(J23, out2);
            default: field = '0;
        endcase
    end

    assign r_smp = q15_t'(lfsr[15:0]);

    pbit_node u_node (
        .CLK     (CLK),
        .RST     (RST),
        .load    (~phase[0]),
        .i_in    (field),
        .r       (r_smp),
        .t       (),
        .bit_out (node_bit)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            lfsr  <= LFSR_SEED;
            phase <= 3'd0;
            out1  <= 1'b0;
            out2  <= 1'b0;
            out3  <= 1'b0;
        end else begin
            lfsr  <= lfsr_next(lfsr);
            phase <= (phase == 3'd5) ? 3'd0 : phase + 3'd1;
            case (phase)
                3'd1: out1 <= node_bit;
                3'd3: out2 <= node_bit;
                3'd5: out3 <= node_bit;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_top_level.sv
// Self-checking bench for top_level: node table, reset, LFSR,
// Gibbs-model lockstep, sampling statistics and random mid-sweep resets.
module tb_top_level;

    localparam logic [31:0] SEED = 32'hACE1_2345;
    localparam int NRUN = 78000;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic o1, o2, o3;
    logic p1, p2, p3;

    logic               nrst = 1'b1;
    logic               nload = 1'b0;
    logic signed [7:0]  ni = '0;
    logic signed [15:0] nr = '0;
    logic signed [15:0] nt;
    logic               nbit;

    top_level dut (
        .CLK(CLK), .RST(RST), .out1(o1), .out2(o2), .out3(o3)
    );

    top_level #(.B3(8'sd7)) dut7 (
        .CLK(CLK), .RST(RST), .out1(p1), .out2(p2), .out3(p3)
    );

    pbit_node u_node (
        .CLK(CLK), .RST(nrst), .load(nload), .i_in(ni),
        .r(nr), .t(nt), .bit_out(nbit)
    );

    always #5 CLK = ~CLK;

    int vec = 0;
    int bad = 0;

    task automatic chk(string nm, longint act, longint exp);
        vec++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    // Behavioural Gibbs model: spins as +/-1 integers
    int          bias [2][3];
    int          jj   [3][3];
    int          mm   [2][3];
    int          pt   [2];
    logic [31:0] ml;
    int          cyc;

    function automatic int tanhq(int i);
        int c;
        c = (i > 7) ? 7 : ((i < -8) ? -8 : i);
        return int'($tanh(real'(c)) * 32767.0);
    endfunction

    function automatic int field(int d, int k);
        int f;
        f = bias[d][k];
        for (int j = 0; j < 3; j++)
            if (j != k)
                f += jj[k][j] * mm[d][j];
        return f;
    endfunction

    function automatic logic [2:0] mbits(int d);
        return {mm[d][0] > 0, mm[d][1] > 0, mm[d][2] > 0};
    endfunction

    task automatic model_edge(logic rst);
        int p, k, r;
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                for (int q = 0; q < 3; q++)
                    mm[d][q] = -1;
                pt[d] = 0;
            end
            ml  = SEED;
            cyc = 0;
        end else begin
            p = cyc % 6;
            k = p / 2;
            r = int'($signed(ml[15:0]));
            for (int d = 0; d < 2; d++) begin
                if (p % 2 == 0)
                    pt[d] = tanhq(field(d, k));
                else
                    mm[d][k] = (pt[d] > r) ? 1 : -1;
            end
            ml = {ml[30:0], ml[31] ^ ml[21] ^ ml[1] ^ ml[0]};
            cyc++;
        end
    endtask

    logic [2:0] prevo;
    int         pcyc;

    task automatic step();
        prevo = {o1, o2, o3};
        pcyc  = cyc;
        @(posedge CLK);
        model_edge(RST);
        #1;
    endtask

    task automatic chk_model();
        chk("outs", {o1, o2, o3}, mbits(0));
        chk("outs_b3", {p1, p2, p3}, mbits(1));
    endtask

    task automatic chk_toggle();
        logic [2:0] ch, allow;
        ch    = prevo ^ {o1, o2, o3};
        allow = (pcyc % 2 == 1) ? (3'b100 >> (pcyc % 6 / 2)) : 3'b000;
        chk("one_toggle", $countones(ch) <= 1, 1);
        chk("toggle_phase", (ch & ~allow) == 3'b000, 1);
    endtask

    typedef struct {
        int i;
        int r;
        int t;
        int b;
    } vec_t;

    vec_t tv [16];

    int         cnt [8];
    int         c3, nsamp;
    real        w [8];
    real        z, pe, pf;
    logic [31:0] r1;

    initial begin
        bias = '{'{1, -1, -2}, '{1, -1, 7}};
        jj   = '{'{0, -1, 2}, '{-1, 0, 2}, '{2, 2, 0}};
        tv = '{
            '{0, -1, 0, 1},           '{0, 0, 0, 0},
            '{1, 24954, 24955, 1},    '{1, 24955, 24955, 0},
            '{-1, -24956, -24955, 1}, '{-1, -24955, -24955, 0},
            '{2, 31587, 31588, 1},    '{3, 32604, 32605, 1},
            '{7, 32767, 32767, 0},    '{100, 32766, 32767, 1},
            '{-100, -32768, -32767, 1}, '{-8, -32767, -32767, 0},
            '{-128, -32768, -32767, 1}, '{127, 0, 32767, 1},
            '{-4, -32746, -32745, 1}, '{-3, 0, -32605, 0}
        };
        for (int s = 0; s < 8; s++)
            cnt[s] = 0;
        c3    = 0;
        nsamp = 0;
        model_edge(1'b1);

        // Standalone node: clamp, ROM and strict compare
        @(posedge CLK);
        #1 nrst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ni    = 8'(tv[i].i);
            nload = 1'b1;
            @(posedge CLK);
            #1 nload = 1'b0;
            nr = 16'(tv[i].r);
            #1;
            chk($sformatf("node_t[%0d]", i), nt, tv[i].t);
            chk($sformatf("node_bit[%0d]", i), nbit, tv[i].b);
        end

        // Reset held for 3 cycles
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_outs", {o1, o2, o3}, 0);
            chk("rst_lfsr", dut.lfsr, SEED);
        end

        // First sweep step from all-zero outputs: node 1 has I = 0
        RST = 1'b0;
        step();
        chk("n1_T", int'(dut.u_node.t), 0);
        r1 = ml;
        step();
        chk("n1_out", o1, r1[15]);
        chk_model();

        // Lockstep run against the model
        for (int n = 2; n < NRUN; n++) begin
            step();
            chk_model();
            if (n < 60)
                chk_toggle();
            if (n < 1000) begin
                chk("lfsr", dut.lfsr, ml);
                chk("lfsr_nz", dut.lfsr != 0, 1);
            end
            if (cyc % 6 == 0) begin
                cnt[{o1, o2, o3}]++;
                c3 += p3;
                nsamp++;
            end
        end

        // Boltzmann statistics, E from the spin energy
        z = 0.0;
        for (int s = 0; s < 8; s++) begin
            int a, b, c;
            a = s[2] ? 1 : -1;
            b = s[1] ? 1 : -1;
            c = s[0] ? 1 : -1;
            w[s] = $exp(real'(a - b - 2*c - a*b + 2*a*c + 2*b*c));
            z += w[s];
        end
        foreach (cnt[s]) begin
            if (s == 0 || s == 4) begin
                pe = w[s] / z;
                pf = real'(cnt[s]) / real'(nsamp);
                chk($sformatf("freq%0d_x1000", s),
                    (pf > pe - 0.025 && pf < pe + 0.025) ? 1 : 0, 1);
            end
        end
        chk("freq001_low", cnt[1] * 1000 < nsamp, 1);
        chk("b3_out3_high", c3 * 100 > nsamp * 99, 1);

        // Random mid-sweep resets
        for (int k = 0; k < 6; k++) begin
            int pre, hold;
            pre  = $urandom_range(11, 1);
            hold = $urandom_range(2, 1);
            for (int i = 0; i < pre; i++) begin
                step();
                chk_model();
            end
            RST = 1'b1;
            for (int i = 0; i < hold; i++) begin
                step();
                chk("midrst_outs", {o1, o2, o3, p1, p2, p3}, 0);
                chk("midrst_lfsr", dut.lfsr, SEED);
            end
            RST = 1'b0;
            for (int i = 0; i < 14; i++) begin
                step();
                chk_model();
                chk_toggle();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule
